// File: rtl/uart_frame_decoder.sv
// uart_frame_decoder
// Turns the UART receive byte stream into memory-write words and dump requests.
// A frame is START b0 b1 b2 b3 STOP. When the STOP byte arrives, the frame is
// loaded into a one-word output register that is handed over on a valid/ready
// handshake, so the next frame can be parsed while the current word waits.
// Frame errors pulse frame_err and are counted in a saturating counter.
//
// State table:
//   state       | meaning
//   IDLE        | waiting for START; DUMP pulses dump_req, other bytes ignored
//   PAYLOAD     | collecting b0..b3 at index idx, each byte range-checked
//   EXPECT_STOP | four bytes held; only STOP completes the frame
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   rx_data    received byte, qualified by rx_valid
//   rx_valid   single-cycle strobe per received byte
//   wr_valid   wr_addr/wr_data hold a complete word
//   wr_ready   consumer accepts the word this cycle
//   wr_addr    {b0[4:0], b1[4:0]}
//   wr_data    {b2[5:0], b3[5:0]}
//   dump_req   one-cycle pulse when a DUMP byte is received
//   frame_err  one-cycle pulse on any frame error
//   err_count  number of frame errors, saturates at 255
//   busy       parser is mid-frame or a word is pending
module uart_frame_decoder #(
    parameter int CLK_FREQ      = 25000000,
    parameter int BAUD          = 115200,
    parameter int TIMEOUT_BYTES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        wr_valid,
    input  logic        wr_ready,
    output logic [9:0]  wr_addr,
    output logic [11:0] wr_data,
    output logic        dump_req,
    output logic        frame_err,
    output logic [7:0]  err_count,
    output logic        busy
);

    localparam int TIMEOUT_CYCLES = TIMEOUT_BYTES * 10 * (CLK_FREQ / BAUD);
    localparam int TW             = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] BYTE_START = 8'hF5;
    localparam logic [7:0] BYTE_STOP  = 8'hFA;
    localparam logic [7:0] BYTE_DUMP  = 8'hF6;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        PAYLOAD     = 2'd1,
        EXPECT_STOP = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [1:0]    idx, idx_nxt;
    logic [TW-1:0] cnt;
    logic [9:0]    addr_buf;
    logic [11:0]   data_buf;

    logic is_start, is_stop, is_dump;
    logic range_ok, timeout;
    logic err_evt, dump_evt, commit_evt, store_en;
    logic overrun, err_any, load;

    assign is_start = (rx_data == BYTE_START);
    assign is_stop  = (rx_data == BYTE_STOP);
    assign is_dump  = (rx_data == BYTE_DUMP);

    // Address bytes carry 5 useful bits, data bytes carry 6.
    assign range_ok = (idx < 2'd2) ? (rx_data[7:5] == 3'b000) : (rx_data[7:6] == 2'b00);

    // A byte arriving on the expiry cycle takes priority over the timeout.
    assign timeout = (state != IDLE) && !rx_valid && (cnt == TIMEOUT_LAST);

    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        err_evt    = 1'b0;
        dump_evt   = 1'b0;
        commit_evt = 1'b0;
        store_en   = 1'b0;
        case (state)
            IDLE: begin
                if (rx_valid) begin
                    if (is_start) begin
                        state_nxt = PAYLOAD;
                        idx_nxt   = 2'd0;
                    end else if (is_dump) begin
                        dump_evt = 1'b1;
                    end
                end
            end
            PAYLOAD: begin
                if (rx_valid) begin
                    if (is_start) begin
                        err_evt = 1'b1;
                        idx_nxt = 2'd0;
                    end else if (is_dump) begin
                        err_evt   = 1'b1;
                        dump_evt  = 1'b1;
                        state_nxt = IDLE;
                    end else if (is_stop) begin
                        err_evt   = 1'b1;
                        state_nxt = IDLE;
                    end else if (range_ok) begin
                        store_en = 1'b1;
                        if (idx == 2'd3) begin
                            state_nxt = EXPECT_STOP;
                        end else begin
                            idx_nxt = 2'(idx + 2'd1);
                        end
                    end else begin
                        err_evt   = 1'b1;
                        state_nxt = IDLE;
                    end
                end else if (timeout) begin
                    err_evt   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            EXPECT_STOP: begin
                if (rx_valid) begin
                    if (is_stop) begin
                        commit_evt = 1'b1;
                        state_nxt  = IDLE;
                    end else if (is_start) begin
                        err_evt   = 1'b1;
                        state_nxt = PAYLOAD;
                        idx_nxt   = 2'd0;
                    end else if (is_dump) begin
                        err_evt   = 1'b1;
                        dump_evt  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        err_evt   = 1'b1;
                        state_nxt = IDLE;
                    end
                end else if (timeout) begin
                    err_evt   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // A commit into an occupied, non-draining register drops the new frame.
    assign overrun = commit_evt && wr_valid && !wr_ready;
    assign load    = commit_evt && !overrun;
    assign err_any = err_evt || overrun;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= 2'd0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (rx_valid || (state == IDLE) || timeout) begin
            cnt <= '0;
        end else begin
            cnt <= TW'(cnt + 1'b1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_buf <= '0;
            data_buf <= '0;
        end else if (store_en) begin
            case (idx)
                2'd0:    addr_buf[9:5]  <= rx_data[4:0];
                2'd1:    addr_buf[4:0]  <= rx_data[4:0];
                2'd2:    data_buf[11:6] <= rx_data[5:0];
                default: data_buf[5:0]  <= rx_data[5:0];
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_valid <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else if (load) begin
            wr_valid <= 1'b1;
            wr_addr  <= addr_buf;
            wr_data  <= data_buf;
        end else if (wr_ready) begin
            wr_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dump_req  <= 1'b0;
            frame_err <= 1'b0;
            err_count <= 8'd0;
        end else begin
            dump_req  <= dump_evt;
            frame_err <= err_any;
            if (err_any && (err_count != 8'hFF)) begin
                err_count <= 8'(err_count + 8'd1);
            end
        end
    end

    assign busy = (state != IDLE) || wr_valid;

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Directed bench for uart_frame_decoder, built with a 1-byte-time timeout
// (10 * (25000000/115200) = 2170 cycles) so the timeout is reachable.
module tb_uart_frame_decoder;

    localparam int T = 2170;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        wr_valid;
    logic        wr_ready;
    logic [9:0]  wr_addr;
    logic [11:0] wr_data;
    logic        dump_req;
    logic        frame_err;
    logic [7:0]  err_count;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_err = 0;

    int   err_pulses = 0;
    int   wr_seen = 0;
    logic watch = 1'b0;

    uart_frame_decoder #(
        .CLK_FREQ(25000000),
        .BAUD(115200),
        .TIMEOUT_BYTES(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .dump_req(dump_req),
        .frame_err(frame_err),
        .err_count(err_count),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err) err_pulses <= err_pulses + 1;
        if (watch && wr_valid) wr_seen <= wr_seen + 1;
    end

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        n_cmp++; if (wr_valid !== 1'b0) begin n_bad++; $display("FAIL reset_wr_valid: got %b expected 0", wr_valid); end
        n_cmp++; if (wr_addr !== 10'h000) begin n_bad++; $display("FAIL reset_wr_addr: got %h expected 000", wr_addr); end
        n_cmp++; if (wr_data !== 12'h000) begin n_bad++; $display("FAIL reset_wr_data: got %h expected 000", wr_data); end
        n_cmp++; if (err_count !== 8'd0) begin n_bad++; $display("FAIL reset_err_count: got %0d expected 0", err_count); end
        n_cmp++; if ({dump_req, frame_err, busy} !== 3'b000) begin n_bad++; $display("FAIL reset_pulses_busy: got %b expected 000", {dump_req, frame_err, busy}); end
        rst = 1'b0;
        idle(2);
        n_cmp++; if ({wr_valid, busy, err_count} !== 10'd0) begin n_bad++; $display("FAIL post_reset_idle: got %h expected 0", {wr_valid, busy, err_count}); end
    endtask

    task automatic test_basic_frame;
        wr_ready = 1'b1;
        send_byte(8'hF5);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy: got %b expected 1", busy); end
        send_byte(8'h03); send_byte(8'h1F); send_byte(8'h2A); send_byte(8'h15);
        n_cmp++; if (wr_valid !== 1'b0) begin n_bad++; $display("FAIL basic_early_valid: got %b expected 0", wr_valid); end
        send_byte(8'hFA);
        n_cmp++; if (wr_valid !== 1'b1) begin n_bad++; $display("FAIL basic_wr_valid: got %b expected 1", wr_valid); end
        n_cmp++; if (wr_addr !== 10'h07F) begin n_bad++; $display("FAIL basic_wr_addr: got %h expected 07f", wr_addr); end
        n_cmp++; if (wr_data !== 12'hA95) begin n_bad++; $display("FAIL basic_wr_data: got %h expected a95", wr_data); end
        n_cmp++; if ({frame_err, err_count} !== 9'd0) begin n_bad++; $display("FAIL basic_no_err: got %h expected 0", {frame_err, err_count}); end
        idle(1);
        n_cmp++; if ({wr_valid, busy} !== 2'b00) begin n_bad++; $display("FAIL basic_drain: got %b expected 00", {wr_valid, busy}); end
    endtask

    task automatic test_back_to_back;
        wr_ready = 1'b1;
        send_byte(8'hF5); send_byte(8'h00); send_byte(8'h01); send_byte(8'h00); send_byte(8'h02); send_byte(8'hFA);
        n_cmp++; if ({wr_valid, wr_addr, wr_data} !== {1'b1, 10'h001, 12'h002}) begin n_bad++; $display("FAIL b2b_first: got %h expected %h", {wr_valid, wr_addr, wr_data}, {1'b1, 10'h001, 12'h002}); end
        send_byte(8'hF5);
        n_cmp++; if (wr_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_drop: got %b expected 0", wr_valid); end
        send_byte(8'h00); send_byte(8'h02); send_byte(8'h00); send_byte(8'h03); send_byte(8'hFA);
        n_cmp++; if ({wr_valid, wr_addr, wr_data} !== {1'b1, 10'h002, 12'h003}) begin n_bad++; $display("FAIL b2b_second: got %h expected %h", {wr_valid, wr_addr, wr_data}, {1'b1, 10'h002, 12'h003}); end
        idle(1);
    endtask

    task automatic test_backpressure;
        wr_ready = 1'b0;
        send_byte(8'hF5); send_byte(8'h00); send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'hFA);
        n_cmp++; if ({wr_valid, wr_addr} !== {1'b1, 10'h001}) begin n_bad++; $display("FAIL bp_frame_a: got %h expected %h", {wr_valid, wr_addr}, {1'b1, 10'h001}); end
        send_byte(8'hF5); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04); send_byte(8'h05); send_byte(8'hFA);
        exp_err = exp_err + 1;
        n_cmp++; if (frame_err !== 1'b1) begin n_bad++; $display("FAIL bp_overrun_pulse: got %b expected 1", frame_err); end
        n_cmp++; if (err_count !== 8'(exp_err)) begin n_bad++; $display("FAIL bp_err_count: got %0d expected %0d", err_count, exp_err); end
        n_cmp++; if ({wr_valid, wr_addr, wr_data} !== {1'b1, 10'h001, 12'h000}) begin n_bad++; $display("FAIL bp_word_kept: got %h expected %h", {wr_valid, wr_addr, wr_data}, {1'b1, 10'h001, 12'h000}); end
        idle(1);
        n_cmp++; if ({frame_err, wr_valid} !== 2'b01) begin n_bad++; $display("FAIL bp_hold: got %b expected 01", {frame_err, wr_valid}); end
        wr_ready = 1'b1;
        idle(1);
        n_cmp++; if (wr_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release: got %b expected 0", wr_valid); end
        // commit in the same cycle the pending word is accepted
        wr_ready = 1'b0;
        send_byte(8'hF5); send_byte(8'h00); send_byte(8'h03); send_byte(8'h00); send_byte(8'h00); send_byte(8'hFA);
        send_byte(8'hF5); send_byte(8'h00); send_byte(8'h04); send_byte(8'h00); send_byte(8'h01);
        n_cmp++; if ({wr_valid, wr_addr} !== {1'b1, 10'h003}) begin n_bad++; $display("FAIL bp_frame_c: got %h expected %h", {wr_valid, wr_addr}, {1'b1, 10'h003}); end
        wr_ready = 1'b1;
        send_byte(8'hFA);
        n_cmp++; if ({wr_valid, wr_addr, wr_data, frame_err} !== {1'b1, 10'h004, 12'h001, 1'b0}) begin n_bad++; $display("FAIL bp_commit_on_ready: got %h expected %h", {wr_valid, wr_addr, wr_data, frame_err}, {1'b1, 10'h004, 12'h001, 1'b0}); end
        idle(1);
        n_cmp++; if ({wr_valid, err_count} !== {1'b0, 8'(exp_err)}) begin n_bad++; $display("FAIL bp_final: got %h expected %h", {wr_valid, err_count}, {1'b0, 8'(exp_err)}); end
    endtask

    task automatic test_bad_frames;
        int p0;
        wr_ready = 1'b1;
        wr_seen  = 0;
        watch    = 1'b1;
        p0       = err_pulses;
        send_byte(8'hF5); send_byte(8'h01); send_byte(8'h02); send_byte(8'hFA);
        n_cmp++; if (frame_err !== 1'b1) begin n_bad++; $display("FAIL bad_short: got %b expected 1", frame_err); end
        send_byte(8'hF5); send_byte(8'h20);
        n_cmp++; if ({frame_err, busy} !== 2'b10) begin n_bad++; $display("FAIL bad_range: got %b expected 10", {frame_err, busy}); end
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'hFA);
        send_byte(8'hF5); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        n_cmp++; if (frame_err !== 1'b1) begin n_bad++; $display("FAIL bad_long: got %b expected 1", frame_err); end
        send_byte(8'hFA);
        idle(2);
        watch   = 1'b0;
        exp_err = exp_err + 3;
        n_cmp++; if (err_pulses - p0 !== 3) begin n_bad++; $display("FAIL bad_pulse_count: got %0d expected 3", err_pulses - p0); end
        n_cmp++; if (err_count !== 8'(exp_err)) begin n_bad++; $display("FAIL bad_err_count: got %0d expected %0d", err_count, exp_err); end
        n_cmp++; if (wr_seen !== 0) begin n_bad++; $display("FAIL bad_wr_valid_seen: got %0d expected 0", wr_seen); end
    endtask

    task automatic test_dump;
        send_byte(8'hF6);
        n_cmp++; if ({dump_req, frame_err} !== 2'b10) begin n_bad++; $display("FAIL dump_idle_pulse: got %b expected 10", {dump_req, frame_err}); end
        idle(1);
        n_cmp++; if ({dump_req, err_count} !== {1'b0, 8'(exp_err)}) begin n_bad++; $display("FAIL dump_idle_one_cycle: got %h expected %h", {dump_req, err_count}, {1'b0, 8'(exp_err)}); end
        send_byte(8'hF5); send_byte(8'h01); send_byte(8'hF6);
        exp_err = exp_err + 1;
        n_cmp++; if ({dump_req, frame_err} !== 2'b11) begin n_bad++; $display("FAIL dump_abort_pulses: got %b expected 11", {dump_req, frame_err}); end
        idle(1);
        n_cmp++; if ({dump_req, busy, err_count} !== {2'b00, 8'(exp_err)}) begin n_bad++; $display("FAIL dump_abort_after: got %h expected %h", {dump_req, busy, err_count}, {2'b00, 8'(exp_err)}); end
    endtask

    task automatic test_timeout;
        wr_ready = 1'b1;
        send_byte(8'hF5); send_byte(8'h01);
        idle(T - 1);
        n_cmp++; if ({frame_err, busy} !== 2'b01) begin n_bad++; $display("FAIL to_before_expiry: got %b expected 01", {frame_err, busy}); end
        idle(1);
        exp_err = exp_err + 1;
        n_cmp++; if ({frame_err, busy} !== 2'b10) begin n_bad++; $display("FAIL to_expiry: got %b expected 10", {frame_err, busy}); end
        n_cmp++; if (err_count !== 8'(exp_err)) begin n_bad++; $display("FAIL to_err_count: got %0d expected %0d", err_count, exp_err); end
        send_byte(8'hF5); send_byte(8'h01);
        idle(T - 1);
        send_byte(8'h02);
        n_cmp++; if ({frame_err, busy} !== 2'b01) begin n_bad++; $display("FAIL to_byte_wins: got %b expected 01", {frame_err, busy}); end
        send_byte(8'h03); send_byte(8'h04); send_byte(8'hFA);
        n_cmp++; if ({wr_valid, wr_addr, wr_data} !== {1'b1, 10'h022, 12'h0C4}) begin n_bad++; $display("FAIL to_frame_done: got %h expected %h", {wr_valid, wr_addr, wr_data}, {1'b1, 10'h022, 12'h0C4}); end
        n_cmp++; if (err_count !== 8'(exp_err)) begin n_bad++; $display("FAIL to_no_extra_err: got %0d expected %0d", err_count, exp_err); end
        idle(1);
    endtask

    task automatic test_saturation;
        for (int i = 0; i < 260; i++) begin
            send_byte(8'hF5); send_byte(8'hFA);
            exp_err = (exp_err < 255) ? exp_err + 1 : 255;
            if (i == 100) begin
                n_cmp++; if (err_count !== 8'(exp_err)) begin n_bad++; $display("FAIL sat_mid: got %0d expected %0d", err_count, exp_err); end
            end
        end
        n_cmp++; if ({frame_err, err_count} !== {1'b1, 8'd255}) begin n_bad++; $display("FAIL sat_final: got %h expected %h", {frame_err, err_count}, {1'b1, 8'd255}); end
    endtask

    task automatic test_reset_mid_frame;
        wr_ready = 1'b0;
        send_byte(8'hF5); send_byte(8'h00); send_byte(8'h05); send_byte(8'h00); send_byte(8'h00); send_byte(8'hFA);
        n_cmp++; if ({wr_valid, wr_addr} !== {1'b1, 10'h005}) begin n_bad++; $display("FAIL rst_pending_word: got %h expected %h", {wr_valid, wr_addr}, {1'b1, 10'h005}); end
        send_byte(8'hF5); send_byte(8'h01);
        #1;
        rst = 1'b1;
        #1;
        n_cmp++; if ({wr_valid, wr_addr, wr_data} !== 23'd0) begin n_bad++; $display("FAIL rst_async_word: got %h expected 0", {wr_valid, wr_addr, wr_data}); end
        n_cmp++; if ({dump_req, frame_err, busy, err_count} !== 11'd0) begin n_bad++; $display("FAIL rst_async_status: got %h expected 0", {dump_req, frame_err, busy, err_count}); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_err = 0;
        send_byte(8'h02); send_byte(8'h03); send_byte(8'hFA);
        idle(1);
        n_cmp++; if ({wr_valid, busy, err_count} !== 10'd0) begin n_bad++; $display("FAIL rst_frame_aborted: got %h expected 0", {wr_valid, busy, err_count}); end
    endtask

    initial begin
        rst      = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        wr_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_basic_frame();
        test_back_to_back();
        test_backpressure();
        test_bad_frames();
        test_dump();
        test_timeout();
        test_saturation();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_frame_decoder.md
Name: uart_frame_decoder

Overview:
Parses the raw byte stream from the UART receiver into validated memory-write words and dump requests. It sits between uart_rx (o_data/o_valid) and the memory-load write sequencer, and replaces the ad-hoc byte capture in the FPGA top level. Each word is presented on a valid/ready handshake with a one-word output register, so a frame can be parsed while the previous word is still pending. It also adds frame checking, inter-byte timeout and an error counter for host-side debug.

Parameters:
CLK_FREQ, 25000000, system clock in Hz
BAUD, 115200, UART bit rate
TIMEOUT_BYTES, 16, inter-byte gap limit in byte times; TIMEOUT_CYCLES = TIMEOUT_BYTES*10*(CLK_FREQ/BAUD) using integer division (default 34720)

Ports:
clk  input  1  system clock
rst  input  1  reset; asynchronous, active-high
rx_data  input  8  received byte, valid only while rx_valid is high
rx_valid  input  1  single-cycle strobe for each received byte
wr_valid  output  1  wr_addr/wr_data hold a complete word
wr_ready  input  1  consumer accepts the word this cycle
wr_addr  output  10  {b0[4:0], b1[4:0]}
wr_data  output  12  {b2[5:0], b3[5:0]}
dump_req  output  1  one-cycle pulse when the DUMP byte is received
frame_err  output  1  one-cycle pulse on any frame error
err_count  output  8  count of frame errors, saturates at 255
busy  output  1  high when parser state is not IDLE or wr_valid is high

Behaviour:
- Control bytes: START=0xF5, STOP=0xFA, DUMP=0xF6. Frame format: START b0 b1 b2 b3 STOP.
- Reset: parser goes to IDLE. Timeout counter, byte index, wr_valid, dump_req, frame_err and err_count all clear to 0. wr_addr/wr_data clear to 0. A pending word is discarded. Reset asserted mid-frame aborts the frame with no error counted.
- Parser FSM (advances only on rx_valid, except on timeout):
  - IDLE: START -> PAYLOAD with idx=0. DUMP -> dump_req. Any other byte is ignored with no error.
  - PAYLOAD: START restarts the frame (idx=0) and counts an error. DUMP aborts the frame, pulses dump_req, counts an error and goes to IDLE. STOP before 4 bytes is a short-frame error -> IDLE.
    - A data byte is range-checked: idx 0/1 require bits[7:5]=0; idx 2/3 require bits[7:6]=0. A failing byte is an error -> IDLE.
    - A passing byte is stored in b[idx]. When idx=3, go to EXPECT_STOP; otherwise idx increments.
  - EXPECT_STOP: STOP commits the frame, then -> IDLE. START is an error and restarts the frame. DUMP is handled as in PAYLOAD. Any other byte is a long-frame error -> IDLE.
- Commit: if wr_valid=0, or wr_valid&&wr_ready in the same cycle, the output register loads and wr_valid=1. Otherwise the commit is an overrun error, the new frame is dropped and the old word is kept.
- Output register: wr_addr/wr_data stay stable while wr_valid&&!wr_ready. wr_valid clears on wr_ready unless a commit happens in the same cycle.
- Timeout: the counter runs only in PAYLOAD/EXPECT_STOP and clears on every rx_valid. When it reaches TIMEOUT_CYCLES-1 without a byte, this is an error -> IDLE. If rx_valid coincides with expiry, the byte wins.
- Latency: dump_req, frame_err and the wr_valid rise are all registered, appearing one cycle after the rx_valid of the triggering byte.
- Multiple errors caused by one byte count as one error. err_count increments by 1 per frame_err pulse and holds at 255.

Test Plan:
- Basic frame: rx F5 03 1F 2A 15 FA with wr_ready=1 -> wr_valid pulses one cycle after FA, wr_addr=0x07F, wr_data=0xA95, err_count=0.
- Back-pressure and overrun: wr_ready=0; send frame A (addr 0x001), then frame B -> B's STOP causes a frame_err pulse, err_count=1, wr_addr stays 0x001. Raise wr_ready -> wr_valid drops next cycle.
- Bad frames: short (F5 01 02 FA), bad range (F5 20 00 00 00 FA), long (F5 00 00 00 00 00 FA) -> three frame_err pulses, err_count=3, wr_valid never set.
- Dump: F6 in IDLE -> dump_req=1 for exactly one cycle, err_count unchanged. F5 01 F6 -> dump_req pulse, err_count+1, busy=0 afterwards.
- Timeout with TIMEOUT_BYTES=1 (2170 cycles): F5 01 then idle 2170 cycles -> frame_err, parser IDLE. A byte on cycle 2169 instead is accepted and the frame completes.
- Saturation and reset: 260 short frames -> err_count=255. Assert rst mid-frame with wr_valid=1 -> all outputs 0 immediately.
